// File: rtl/reqgnt_pkg.sv
// Shared constants and types for the req/gnt responder: default sizing,
// derived widths and the stored timestamp type.
package reqgnt_pkg;

   localparam int DEF_MAX_OUT = 8;
   localparam int DEF_MIN_LAT = 2;
   localparam int DEF_MAX_LAT = 8;
   localparam int DEF_TS_W    = 4;

   localparam int CNT_W = $clog2(DEF_MAX_OUT) + 1;
   localparam int PTR_W = $clog2(DEF_MAX_OUT);

   typedef logic [DEF_TS_W-1:0] ts_t;

   // Count width must hold the value DEPTH itself, hence the extra bit.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/reqgnt_responder_if.sv
// Request/grant bundle between initiators and the responder, with the
// outstanding/full/overflow status the responder reports back.
interface reqgnt_responder_if
   import reqgnt_pkg::*;
#(
   parameter int MAX_OUT = DEF_MAX_OUT
);

   logic                          req;
   logic                          svc_ready;
   logic                          gnt;
   logic [cnt_width(MAX_OUT)-1:0] outstanding;
   logic                          full;
   logic                          overflow_err;

   modport master (
      output req, svc_ready,
      input  gnt, outstanding, full, overflow_err
   );

   modport slave (
      input  req, svc_ready,
      output gnt, outstanding, full, overflow_err
   );

endinterface

// File: rtl/reqgnt_ts_fifo.sv
// Ring buffer of request timestamps in arrival order; the head entry is
// always the oldest outstanding request.
module reqgnt_ts_fifo
   import reqgnt_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_OUT,
   parameter int TS_W  = DEF_TS_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic [TS_W-1:0]             push_ts,
   output logic [TS_W-1:0]             head_ts,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = cnt_width(DEPTH);

   logic [TS_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: count gates every use of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= push_ts;
   end

   assign head_ts = mem_q[head_q];
   assign count   = count_q;

endmodule

// File: rtl/reqgnt_responder.sv
// Grant side of the req/gnt protocol: queues request timestamps and grants
// the oldest once it is old enough and downstream is ready, or at deadline.
module reqgnt_responder
   import reqgnt_pkg::*;
#(
   parameter int MAX_OUT = DEF_MAX_OUT,
   parameter int MIN_LAT = DEF_MIN_LAT,
   parameter int MAX_LAT = DEF_MAX_LAT,
   parameter int TS_W    = DEF_TS_W
) (
   input logic               clk,
   input logic               rst,
   reqgnt_responder_if.slave bus
);

   localparam int CW = cnt_width(MAX_OUT);

   typedef logic [TS_W-1:0] stamp_t;

   localparam stamp_t MIN_AGE = stamp_t'(MIN_LAT);
   localparam stamp_t MAX_AGE = stamp_t'(MAX_LAT);

   stamp_t        now_q, now_d;
   stamp_t        head_ts;
   stamp_t        age;
   logic [CW-1:0] count;
   logic          is_full;
   logic          gnt;
   logic          accept;
   logic          drop;
   logic          ovf_q, ovf_d;

   reqgnt_ts_fifo #(
      .DEPTH (MAX_OUT),
      .TS_W  (TS_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (accept),
      .pop     (gnt),
      .push_ts (now_q),
      .head_ts (head_ts),
      .count   (count)
   );

   // Modular age stays exact because no entry outlives MAX_LAT < 2**TS_W.
   // A grant frees a slot in the same cycle, so a full queue still accepts.
   always_comb begin
      age     = now_q - head_ts;
      is_full = (count == CW'(MAX_OUT));
      gnt     = (count != '0) && (age >= MIN_AGE) &&
                (bus.svc_ready || (age >= MAX_AGE));
      accept  = bus.req && (!is_full || gnt);
      drop    = bus.req && !accept;
      now_d   = now_q + stamp_t'(1);
      ovf_d   = ovf_q | drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         now_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         now_q <= now_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.gnt          = gnt;
   assign bus.outstanding  = count;
   assign bus.full         = is_full;
   assign bus.overflow_err = ovf_q;

endmodule

// File: doc/reqgnt_responder.md
Name: reqgnt_responder

Overview:
Responder (grant side) of the single-bit req/gnt protocol. It accepts request pulses, queues them in arrival order and issues exactly one gnt pulse per accepted req. Each gnt lands between MIN_LAT and MAX_LAT cycles after its req. At most MAX_OUT requests are outstanding at any time. It sits between request initiators and a downstream service that signals when it can absorb a grant.

Parameters:
MAX_OUT, 8, maximum outstanding (accepted, not yet granted) requests; power of two.
MIN_LAT, 2, minimum cycles from req to its gnt; must be ≥1.
MAX_LAT, 8, maximum cycles from req to its gnt (forced deadline); MIN_LAT ≤ MAX_LAT < 2**TS_W.
TS_W, 4, width of the free-running timestamp counter and stored timestamps.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  1  one request per cycle when high
svc_ready  input  1  downstream can take a grant this cycle (early grant allowed)
gnt  output  1  grant for the oldest outstanding request
outstanding  output  $clog2(MAX_OUT)+1  current count of accepted, ungranted requests
full  output  1  outstanding == MAX_OUT
overflow_err  output  1  sticky: a req was dropped

Behaviour:
- Reset (async assert, any cycle):
  - outstanding=0, gnt=0, full=0, overflow_err=0.
  - Timestamp counter, head and tail pointers = 0.
  - All queued requests are discarded; no gnt is issued for them after release.
- Timestamp: now_q increments every cycle, wraps mod 2**TS_W.
- Age of the head entry: age = (now_q − ts[head]) mod 2**TS_W.
- A req sampled at the edge closing cycle t stores ts=t, so age is counted in cycles since the req.
- Accept rule: req is accepted iff outstanding < MAX_OUT, or gnt is high in the same cycle.
  - On accept: ts[tail] ← now_q, tail++ (wraps mod MAX_OUT).
- Drop rule: req while full and gnt low is dropped. overflow_err ← 1 and stays set until rst.
- gnt is combinational from registered state and svc_ready:
  - gnt = (outstanding>0) && (age ≥ MIN_LAT) && (svc_ready || age ≥ MAX_LAT).
  - When age == MAX_LAT, gnt fires regardless of svc_ready.
  - On gnt: head++ (wraps mod MAX_OUT).
- Counter update:
  - accept & !gnt → +1
  - !accept & gnt → −1
  - both or neither → unchanged
- Invariants:
  - gnt is never high while outstanding == 0.
  - outstanding never exceeds MAX_OUT.
  - Grants are strictly in arrival order.
- Deadlines are always met. Entries arrive at most one per cycle, so their ages are distinct and at most one entry reaches MAX_LAT in any cycle. The head is always the oldest entry.
- A req in the same cycle as an empty queue is not granted that cycle (MIN_LAT ≥ 1).
- Timestamp wrap: modular subtraction stays correct because age ≤ MAX_LAT < 2**TS_W.
- full is registered-equivalent: decoded directly from outstanding.

Decomposition:
- Package reqgnt_pkg:
  - default MAX_OUT/MIN_LAT/MAX_LAT/TS_W constants
  - derived CNT_W = $clog2(MAX_OUT)+1 and PTR_W = $clog2(MAX_OUT)
  - typedef ts_t (logic [TS_W-1:0])
- Sub-module reqgnt_ts_fifo: MAX_OUT-deep ring buffer of ts_t.
  - Ports: push/pop, head timestamp output, count.
  - Simultaneous push and pop is allowed when full.
- Top level holds now_q, the age/deadline compare, the accept/drop decision and overflow_err.

Test Plan:
- Single req at cycle 0, svc_ready=1 constantly → gnt exactly at cycle 2; outstanding goes 1 then 0.
- Single req at cycle 0, svc_ready=0 → gnt forced at cycle 8; no gnt in cycles 1–7.
- 8 back-to-back reqs (cycles 0–7), svc_ready=0 → full=1 from cycle 8; gnts at cycles 8–15, one per cycle; outstanding returns to 0 at cycle 16.
- With queue full, req and forced gnt coincide at cycle 8 → req accepted, outstanding stays 8, overflow_err=0. A req at a full cycle without gnt → dropped, overflow_err=1 held until rst.
- 20 reqs spaced every 3 cycles with svc_ready toggling → timestamps wrap past 15; every gnt 2–8 cycles after its req, in order.
- rst asserted mid-cycle with 5 outstanding → outputs clear immediately (async); no gnt after release until new reqs age ≥ 2.
